// File: rtl/prog_loader.sv
// Framed byte-stream loader feeding the core's program memory.
// Ports: clk/reset, in_valid/in_data/in_ready stream, mem_we/mem_addr/mem_wdata, busy/run/load_done/load_err/err_code status.
module prog_loader #(
    parameter int         DEPTH     = 8,
    parameter int         ADDR_W    = 3,
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         TIMEOUT   = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              busy,
    output logic              run,
    output logic              load_done,
    output logic              load_err,
    output logic [1:0]        err_code
);

    // One extra bit so counters can hold the value DEPTH itself.
    localparam int CW = ADDR_W + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_CSUM,
        S_COMMIT
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   r_len;
    logic [7:0]      r_csum;
    logic [7:0]      r_tmo;
    logic [7:0]      r_shadow [DEPTH];
    logic            r_run;
    logic [1:0]      r_err_code;
    logic            r_load_done;
    logic            r_load_err;

    logic            w_ready;
    logic            w_xfer;
    logic            w_tmo_exp;
    logic            w_in_frame;
    logic            w_abort;
    logic [1:0]      w_code;
    logic            w_done;

    assign w_ready    = (r_state != S_COMMIT);
    assign w_xfer     = in_valid && w_ready;
    assign w_in_frame = (r_state == S_LEN) || (r_state == S_DATA) ||
                        (r_state == S_CSUM);
    // Expiry fires on the edge that would bring the count to TIMEOUT.
    assign w_tmo_exp  = (r_tmo == 8'(TIMEOUT - 1));

    always_comb begin
        w_next  = r_state;
        w_abort = 1'b0;
        w_code  = 2'd0;
        w_done  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_xfer && in_data == SYNC_BYTE) begin
                    w_next = S_LEN;
                end
            end
            S_LEN: begin
                if (w_xfer) begin
                    if (in_data == 8'd0 || in_data > 8'(DEPTH)) begin
                        w_abort = 1'b1;
                        w_code  = 2'd1;
                    end else begin
                        w_next = S_DATA;
                    end
                end else if (w_tmo_exp) begin
                    w_abort = 1'b1;
                    w_code  = 2'd3;
                end
            end
            S_DATA: begin
                if (w_xfer) begin
                    if (r_cnt == r_len - CW'(1)) begin
                        w_next = S_CSUM;
                    end
                end else if (w_tmo_exp) begin
                    w_abort = 1'b1;
                    w_code  = 2'd3;
                end
            end
            S_CSUM: begin
                if (w_xfer) begin
                    if (in_data == r_csum) begin
                        w_next = S_COMMIT;
                    end else begin
                        w_abort = 1'b1;
                        w_code  = 2'd2;
                    end
                end else if (w_tmo_exp) begin
                    w_abort = 1'b1;
                    w_code  = 2'd3;
                end
            end
            S_COMMIT: begin
                if (r_cnt == CW'(DEPTH - 1)) begin
                    w_next = S_IDLE;
                    w_done = 1'b1;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
        if (w_abort) begin
            w_next = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_len       <= '0;
            r_csum      <= 8'd0;
            r_tmo       <= 8'd0;
            r_run       <= 1'b0;
            r_err_code  <= 2'd0;
            r_load_done <= 1'b0;
            r_load_err  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_load_done <= w_done;
            r_load_err  <= w_abort;

            if (w_in_frame && !w_xfer && !w_abort) begin
                r_tmo <= r_tmo + 8'd1;
            end else begin
                r_tmo <= 8'd0;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (w_xfer && in_data == SYNC_BYTE) begin
                        r_run      <= 1'b0;
                        r_err_code <= 2'd0;
                    end
                end
                S_LEN: begin
                    if (w_xfer) begin
                        r_len  <= in_data[CW-1:0];
                        r_csum <= in_data;
                        r_cnt  <= '0;
                    end
                end
                S_DATA: begin
                    if (w_xfer) begin
                        r_csum <= r_csum ^ in_data;
                        r_cnt  <= r_cnt + CW'(1);
                    end
                end
                S_CSUM: begin
                    if (w_xfer) begin
                        r_cnt <= '0;
                    end
                end
                S_COMMIT: begin
                    r_cnt <= w_done ? '0 : r_cnt + CW'(1);
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase

            if (w_abort) begin
                r_err_code <= w_code;
            end
            if (w_done) begin
                r_run <= 1'b1;
            end
        end
    end

    // Shadow payload store; contents after reset are irrelevant.
    always_ff @(posedge clk) begin
        if (r_state == S_DATA && w_xfer) begin
            r_shadow[r_cnt[ADDR_W-1:0]] <= in_data;
        end
    end

    assign in_ready  = w_ready;
    assign mem_we    = (r_state == S_COMMIT);
    assign mem_addr  = mem_we ? r_cnt[ADDR_W-1:0] : '0;
    // Entries beyond the frame length are padded with NOOP.
    assign mem_wdata = (mem_we && r_cnt < r_len) ?
                       r_shadow[r_cnt[ADDR_W-1:0]] : 8'h00;
    assign busy      = (r_state != S_IDLE);
    assign run       = r_run;
    assign load_done = r_load_done;
    assign load_err  = r_load_err;
    assign err_code  = r_err_code;

endmodule
